// File: rtl/obuft_bus_arbiter_if.sv
// Bundle between requester logic and the tri-state pad arbiter.
// master = requester side, slave = arbiter side.
interface obuft_bus_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       last;
   logic [NREQ*WIDTH-1:0] data;
   logic                  hiz;
   logic [NREQ-1:0]       gnt;
   logic [OW-1:0]         owner;
   logic [WIDTH-1:0]      bus_i;
   logic                  bus_t;
   logic                  turn_active;

   modport master (
      output req, last, data, hiz,
      input  gnt, owner, bus_i, bus_t, turn_active
   );

   modport slave (
      input  req, last, data, hiz,
      output gnt, owner, bus_i, bus_t, turn_active
   );
endinterface

// File: rtl/obuft_bus_arbiter.sv
// Round-robin owner selection for one shared OBUFT pad group, with a
// registered T control and dead cycles between owners so drivers never overlap.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | pad released, arbitrate among requesters (blocked by hiz)
//   ST_DRIVE | owner drives pad; one beat per cycle with req[owner]=1
//   ST_TURN  | pad released for TURN_CYC cycles, requests ignored
module obuft_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int TURN_CYC = 2,
   parameter int MAX_HOLD = 16
) (
   input logic              clk,
   input logic              rst_n,
   obuft_bus_arbiter_if.slave bus
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            t_q, t_d;
   logic [3:0]      turn_q, turn_d;
   logic [7:0]      hold_q, hold_d;
   logic            fresh_q, fresh_d;

   logic            found;
   logic [OW-1:0]   winner;
   int              start_i;
   logic            sel_req;
   logic            sel_last;
   logic [WIDTH-1:0] sel_data;

   // Search upward from the slot after the last owner, wrapping; after reset
   // the search starts at requester 0.
   always_comb begin
      found   = 1'b0;
      winner  = '0;
      start_i = fresh_q ? 0 : int'(owner_q) + 1;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && j >= start_i && bus.req[j]) begin
            found  = 1'b1;
            winner = OW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && bus.req[j]) begin
            found  = 1'b1;
            winner = OW'(j);
         end
      end
   end

   always_comb begin
      sel_req  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (owner_q == OW'(j)) begin
            sel_req  = bus.req[j];
            sel_last = bus.last[j];
            sel_data = bus.data[j*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         gnt_q   <= '0;
         t_q     <= 1'b1;
         turn_q  <= '0;
         hold_q  <= '0;
         fresh_q <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         t_q     <= t_d;
         turn_q  <= turn_d;
         hold_q  <= hold_d;
         fresh_q <= fresh_d;
      end
   end

   // hold_q counts down remaining beats; the beat seen at zero is the last one.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      t_d     = t_q;
      turn_d  = turn_q;
      hold_d  = hold_q;
      fresh_d = fresh_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.hiz && found) begin
               state_d = ST_DRIVE;
               owner_d = winner;
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
               t_d     = 1'b0;
               hold_d  = 8'(MAX_HOLD - 1);
               fresh_d = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (bus.hiz || !sel_req || sel_last || hold_q == '0) begin
               state_d = ST_TURN;
               gnt_d   = '0;
               t_d     = 1'b1;
               turn_d  = 4'(TURN_CYC - 1);
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         ST_TURN: begin
            if (turn_q == '0) state_d = ST_IDLE;
            else              turn_d  = turn_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.gnt         = gnt_q;
   assign bus.owner       = owner_q;
   assign bus.bus_t       = t_q | bus.hiz;
   assign bus.turn_active = (state_q == ST_TURN);
   assign bus.bus_i       = (state_q == ST_DRIVE) ? sel_data : '0;
endmodule

// File: tb/tb_obuft_bus_arbiter.sv
// Directed and random checks of obuft_bus_arbiter against a transaction-level
// model of ownership, beats and dead time.
module tb_obuft_bus_arbiter;
   localparam int NREQ     = 4;
   localparam int WIDTH    = 8;
   localparam int TURN_CYC = 2;
   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obuft_bus_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   obuft_bus_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // model: who drives (-1 = nobody), last owner, beats taken, dead cycles left
   int m_owner, m_last, m_beats, m_dead;
   bit m_fresh;
   int g_prev, g_dead;
   logic [NREQ-1:0] gnt_prev;

   task automatic model_reset();
      m_owner  = -1;
      m_last   = 0;
      m_beats  = 0;
      m_dead   = 0;
      m_fresh  = 1'b1;
      g_prev   = -1;
      g_dead   = 0;
      gnt_prev = '0;
   endtask

   task automatic model_update();
      bit beat, done;
      int base;
      if (m_owner >= 0) begin
         beat = !bus.hiz && bus.req[m_owner];
         if (beat) m_beats++;
         done = bus.hiz || !bus.req[m_owner] || bus.last[m_owner] || (beat && m_beats == MAX_HOLD);
         if (done) begin
            m_owner = -1;
            m_dead  = TURN_CYC;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else if (!bus.hiz && bus.req != 0) begin
         base = m_fresh ? 0 : m_last + 1;
         for (int k = 0; k < NREQ; k++) begin
            if (m_owner < 0 && bus.req[(base + k) % NREQ]) m_owner = (base + k) % NREQ;
         end
         m_last  = m_owner;
         m_fresh = 1'b0;
         m_beats = 0;
      end
   endtask

   task automatic compare_all();
      logic [NREQ-1:0] eg;
      logic [WIDTH-1:0] ei;
      int own;
      eg = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      ei = (m_owner >= 0) ? bus.data[m_owner*WIDTH +: WIDTH] : '0;
      check_val("gnt", 32'(bus.gnt), 32'(eg));
      check_val("owner", 32'(bus.owner), 32'(m_last));
      check_val("bus_t", 32'(bus.bus_t), 32'((m_owner < 0) || bus.hiz));
      check_val("turn_active", 32'(bus.turn_active), 32'(m_dead > 0));
      check_val("bus_i", 32'(bus.bus_i), 32'(ei));
      check_val("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      check_val("t_low_has_gnt", 32'(bus.bus_t || bus.gnt != 0), 32'd1);
      if (bus.gnt != 0) begin
         own = 0;
         for (int j = 0; j < NREQ; j++) if (bus.gnt[j]) own = j;
         if (gnt_prev == 0 && g_prev >= 0 && own != g_prev)
            check_val("dead_gap", 32'(g_dead >= TURN_CYC), 32'd1);
         g_prev = own;
         g_dead = 0;
      end else begin
         g_dead++;
      end
      gnt_prev = bus.gnt;
   endtask

   // One clock: drive inputs just after a falling edge, check, advance model.
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic h);
      bus.req  = r;
      bus.last = l;
      bus.hiz  = h;
      bus.data = (NREQ*WIDTH)'($urandom());
      #1 compare_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.last = '0;
      bus.hiz  = 1'b0;
      bus.data = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int n_drive, n_turn, n_gnt, n_gnt3, k;
      int own_q[$];
      int at_q[$];
      logic [NREQ-1:0] rq, lq, pg;

      model_reset();
      reset_dut();
      check_val("rst_gnt", 32'(bus.gnt), 32'd0);
      check_val("rst_bus_t", 32'(bus.bus_t), 32'd1);
      check_val("rst_owner", 32'(bus.owner), 32'd0);
      check_val("rst_turn", 32'(bus.turn_active), 32'd0);

      // single requester, three beats
      n_drive = 0; n_turn = 0; n_gnt = 0;
      step(4'b0010, 4'b0000, 1'b0);
      check_val("single_latency", 32'(bus.gnt), 32'b0010);
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0010, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (bus.turn_active) n_turn++;
         step(4'b0000, 4'b0000, 1'b0);
      end
      check_val("single_turn_cycles", 32'(n_turn), 32'(TURN_CYC));

      // round robin, every beat last
      reset_dut();
      pg = '0;
      for (int i = 0; i < 20; i++) begin
         step(4'b1111, 4'b1111, 1'b0);
         if (bus.gnt != 0 && pg == 0) begin
            own_q.push_back(int'(bus.owner));
            at_q.push_back(i);
         end
         pg = bus.gnt;
      end
      check_val("rr_grants", 32'(own_q.size()), 32'd5);
      for (int i = 0; i < own_q.size(); i++) begin
         check_val("rr_owner", 32'(own_q[i]), 32'(i % NREQ));
         if (i > 0) check_val("rr_period", 32'(at_q[i] - at_q[i-1]), 32'(TURN_CYC + 2));
      end

      // hold limit with another requester pending
      reset_dut();
      n_gnt = 0; n_gnt3 = 0;
      for (int i = 0; i < 30; i++) begin
         step(4'b1100, 4'b0000, 1'b0);
         if (bus.gnt == 4'b0100) n_gnt++;
         if (bus.gnt == 4'b1000) n_gnt3++;
      end
      check_val("hold_beats", 32'(n_gnt), 32'(MAX_HOLD));
      check_val("hold_next_owner", 32'(n_gnt3 > 0), 32'd1);

      // hiz during drive, then hiz held in idle
      reset_dut();
      step(4'b0001, 4'b0000, 1'b0);
      step(4'b0001, 4'b0000, 1'b0);
      step(4'b0001, 4'b0000, 1'b1);
      check_val("hiz_to_turn", 32'(bus.turn_active), 32'd1);
      n_gnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(4'b0010, 4'b0000, 1'b1);
         if (bus.gnt != 0) n_gnt++;
      end
      check_val("hiz_blocks_grant", 32'(n_gnt), 32'd0);
      step(4'b0010, 4'b0000, 1'b0);
      check_val("hiz_release_grant", 32'(bus.gnt), 32'b0010);

      // async reset while driving
      reset_dut();
      step(4'b0001, 4'b0000, 1'b0);
      step(4'b0001, 4'b0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_gnt", 32'(bus.gnt), 32'd0);
      check_val("arst_bus_t", 32'(bus.bus_t), 32'd1);
      check_val("arst_bus_i", 32'(bus.bus_i), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // random traffic
      rq = '0;
      for (int i = 0; i < 10000; i++) begin
         rq ^= NREQ'($urandom()) & NREQ'($urandom());
         lq = NREQ'($urandom()) & NREQ'($urandom());
         k  = $urandom_range(0, 31);
         step(rq, lq, k == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
